// File: rtl/sti_serializer.sv
// sti_serializer: parallel-to-serial transmitter for the STI/DAC datapath.
// Captures a 16-bit word plus format controls, expands it into an
// 8/16/24/32-bit frame and shifts it out one bit per clock with a strobe.
module sti_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] pi_data,
  input  logic [1:0]  pi_length,
  input  logic        pi_fill,
  input  logic        pi_msb,
  input  logic        pi_low,
  input  logic        pi_end,
  output logic        busy,
  output logic        so_valid,
  output logic        so_data,
  output logic        done
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] frame_reg, frame_next;
  logic [4:0]  len_m1_reg, len_m1_next;   // frame length minus one
  logic [4:0]  cnt_reg, cnt_next;         // index of the bit currently on so_data
  logic        msb_reg, msb_next;
  logic        end_reg, end_next;
  logic        busy_reg, busy_next;
  logic        valid_reg, valid_next;
  logic        data_reg, data_next;
  logic        done_reg, done_next;

  logic [31:0] frame_new;
  logic [4:0]  len_m1_new;

  // Bit k of an N-bit right-aligned frame in the selected order.
  function automatic logic bit_at(input logic [31:0] f, input logic [4:0] lm1,
                                  input logic msb, input logic [4:0] k);
    logic [4:0] idx;
    idx = msb ? (lm1 - k) : k;
    return f[idx];
  endfunction

  // Frame built from the live inputs; only used at the moment of capture.
  always_comb begin
    frame_new  = 32'h0;
    len_m1_new = {pi_length, 3'b111};
    case (pi_length)
      2'b00: frame_new = {24'h0, (pi_low ? pi_data[15:8] : pi_data[7:0])};
      2'b01: frame_new = {16'h0, pi_data};
      2'b10: frame_new = pi_fill ? {8'h0, pi_data, 8'h0} : {16'h0, pi_data};
      default: frame_new = pi_fill ? {pi_data, 16'h0} : {16'h0, pi_data};
    endcase
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_next  = state_reg;
    frame_next  = frame_reg;
    len_m1_next = len_m1_reg;
    cnt_next    = cnt_reg;
    msb_next    = msb_reg;
    end_next    = end_reg;
    busy_next   = 1'b0;
    valid_next  = 1'b0;
    data_next   = 1'b0;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next  = SEND;
          frame_next  = frame_new;
          len_m1_next = len_m1_new;
          cnt_next    = 5'd0;
          msb_next    = pi_msb;
          end_next    = pi_end;
          busy_next   = 1'b1;
          valid_next  = 1'b1;
          data_next   = bit_at(frame_new, len_m1_new, pi_msb, 5'd0);
        end
      end
      default: begin
        if (cnt_reg == len_m1_reg) begin
          state_next = IDLE;
          cnt_next   = 5'd0;
          done_next  = end_reg;
        end else begin
          cnt_next   = cnt_reg + 5'd1;
          busy_next  = 1'b1;
          valid_next = 1'b1;
          data_next  = bit_at(frame_reg, len_m1_reg, msb_reg, cnt_reg + 5'd1);
        end
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      frame_reg  <= 32'h0;
      len_m1_reg <= 5'd0;
      cnt_reg    <= 5'd0;
      msb_reg    <= 1'b0;
      end_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      data_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      frame_reg  <= frame_next;
      len_m1_reg <= len_m1_next;
      cnt_reg    <= cnt_next;
      msb_reg    <= msb_next;
      end_reg    <= end_next;
      busy_reg   <= busy_next;
      valid_reg  <= valid_next;
      data_reg   <= data_next;
      done_reg   <= done_next;
    end
  end

  assign busy     = busy_reg;
  assign so_valid = valid_reg;
  assign so_data  = data_reg;
  assign done     = done_reg;

endmodule
